// File: rtl/mrx_pkg.sv
// Shared types and checksum helpers for the Manchester RX frame controller.
// Defining MRX_CRC8_EN switches the frame check from XOR to CRC-8 (poly 0x07, init 0x00).
package mrx_pkg;

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RECV   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_SKIP   = 3'd5
    } mrx_state_e;

    localparam logic [7:0]  CRC8_POLY    = 8'h07;
    localparam logic [15:0] MRX_PREAMBLE = 16'hAAD5;

    // Folds one payload byte into the running check value.
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] c;
`ifdef MRX_CRC8_EN
        c = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
`else
        c = acc ^ data;
`endif
        return c;
    endfunction

    // Compares the accumulated payload check against the received checksum byte.
    function automatic logic chk_pass(input logic [7:0] acc, input logic [7:0] chk);
`ifdef MRX_CRC8_EN
        return (acc == chk);
`else
        return ((acc ^ chk) == 8'h00);
`endif
    endfunction

endpackage

// File: rtl/mrx_sat_counter.sv
// Saturating up-counter used for the frame controller status counters.
module mrx_sat_counter
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count up on inc_i, holding at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/manchester_rx_frame_ctrl.sv
// Frame assembler/checker behind the Manchester decoder with an AXI-Stream payload output.
// Build option MRX_CRC8_EN selects CRC-8 frame checking instead of the XOR checksum.
module manchester_rx_frame_ctrl
    import mrx_pkg::*;
#(
    parameter int FRAME_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESYNC_CYCLES  = 4,
    parameter int CNT_W          = 16
)
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_valid,
    output logic             dec_aresetn,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_bad_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             busy
);

    localparam int IDX_W = $clog2(FRAME_SIZE);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RS_W  = $clog2(RESYNC_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_SIZE - 1);
    localparam logic [IDX_W-1:0] TLAST_IDX = IDX_W'(FRAME_SIZE - 2);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RS_W-1:0]  RS_INIT   = RS_W'(RESYNC_CYCLES - 1);

    mrx_state_e       state_q;
    logic [RS_W-1:0]  rs_cnt_q;
    logic [TMR_W-1:0] timer_q;
    logic [IDX_W-1:0] idx_q, rd_idx_q, skip_idx_q;
    logic [7:0]       acc_q;
    logic [7:0]       frame_q [FRAME_SIZE];
    logic             dec_aresetn_q, tvalid_q, tlast_q;
    logic [7:0]       tdata_q;

    logic             pass_s, timeout_s;
    logic [IDX_W-1:0] skip_nxt_s, skip_idx_d, rd_nxt_s;
    logic             ok_inc_s, bad_inc_s, ovf_inc_s, to_inc_s;

    assign pass_s     = chk_pass(acc_q, frame_q[LAST_IDX]);
    assign timeout_s  = (timer_q == TMR_LAST);
    assign skip_nxt_s = (skip_idx_q == LAST_IDX) ? IDX_W'(0) : (skip_idx_q + IDX_W'(1));
    assign skip_idx_d = byte_in_valid ? skip_nxt_s : skip_idx_q;
    assign rd_nxt_s   = rd_idx_q + IDX_W'(1);

    // Status counter increment strobes for the current cycle.
    always_comb begin
        ok_inc_s  = 1'b0;
        bad_inc_s = 1'b0;
        ovf_inc_s = 1'b0;
        to_inc_s  = 1'b0;
        case (state_q)
            ST_CHECK: begin
                ok_inc_s  = pass_s;
                bad_inc_s = ~pass_s;
                ovf_inc_s = byte_in_valid && (skip_idx_q == IDX_W'(0));
            end
            ST_DRAIN: ovf_inc_s = byte_in_valid && (skip_idx_q == IDX_W'(0));
            ST_RECV, ST_SKIP: to_inc_s = ~byte_in_valid && timeout_s;
            default: to_inc_s = 1'b0;
        endcase
    end

    // Frame controller state machine with registered stream and decoder-reset outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_RESYNC;
            rs_cnt_q      <= RS_INIT;
            timer_q       <= TMR_W'(0);
            idx_q         <= IDX_W'(0);
            rd_idx_q      <= IDX_W'(0);
            skip_idx_q    <= IDX_W'(0);
            acc_q         <= 8'h00;
            dec_aresetn_q <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= 8'h00;
            for (int i = 0; i < FRAME_SIZE; i++) begin
                frame_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                ST_RESYNC: begin
                    if (rs_cnt_q == RS_W'(0)) begin
                        state_q       <= ST_IDLE;
                        dec_aresetn_q <= 1'b1;
                    end else begin
                        rs_cnt_q <= rs_cnt_q - RS_W'(1);
                    end
                end
                ST_IDLE: begin
                    timer_q <= TMR_W'(0);
                    if (byte_in_valid && enable) begin
                        frame_q[0] <= byte_in;
                        acc_q      <= chk_step(8'h00, byte_in);
                        idx_q      <= IDX_W'(1);
                        state_q    <= ST_RECV;
                    end else if (byte_in_valid) begin
                        skip_idx_q <= IDX_W'(1);
                        state_q    <= ST_SKIP;
                    end
                end
                ST_RECV: begin
                    if (byte_in_valid) begin
                        frame_q[idx_q] <= byte_in;
                        timer_q        <= TMR_W'(0);
                        // The checksum byte is kept in the buffer, not folded into acc.
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_CHECK;
                        end else begin
                            acc_q <= chk_step(acc_q, byte_in);
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else if (timeout_s) begin
                        state_q       <= ST_RESYNC;
                        rs_cnt_q      <= RS_INIT;
                        dec_aresetn_q <= 1'b0;
                        timer_q       <= TMR_W'(0);
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_CHECK: begin
                    skip_idx_q <= skip_idx_d;
                    timer_q    <= TMR_W'(0);
                    if (pass_s) begin
                        state_q  <= ST_DRAIN;
                        rd_idx_q <= IDX_W'(0);
                        tdata_q  <= frame_q[0];
                        tvalid_q <= 1'b1;
                        tlast_q  <= (FRAME_SIZE == 2) ? 1'b1 : 1'b0;
                    end else begin
                        state_q <= (skip_idx_d != IDX_W'(0)) ? ST_SKIP : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    skip_idx_q <= skip_idx_d;
                    timer_q    <= TMR_W'(0);
                    if (tvalid_q && m_axis_tready) begin
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= (skip_idx_d != IDX_W'(0)) ? ST_SKIP : ST_IDLE;
                        end else begin
                            rd_idx_q <= rd_nxt_s;
                            tdata_q  <= frame_q[rd_nxt_s];
                            tlast_q  <= (rd_nxt_s == TLAST_IDX);
                        end
                    end
                end
                ST_SKIP: begin
                    if (byte_in_valid) begin
                        timer_q <= TMR_W'(0);
                        if (skip_idx_q == LAST_IDX) begin
                            skip_idx_q <= IDX_W'(0);
                            state_q    <= ST_IDLE;
                        end else begin
                            skip_idx_q <= skip_idx_q + IDX_W'(1);
                        end
                    end else if (timeout_s) begin
                        state_q       <= ST_RESYNC;
                        rs_cnt_q      <= RS_INIT;
                        dec_aresetn_q <= 1'b0;
                        skip_idx_q    <= IDX_W'(0);
                        timer_q       <= TMR_W'(0);
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q       <= ST_RESYNC;
                    rs_cnt_q      <= RS_INIT;
                    dec_aresetn_q <= 1'b0;
                    tvalid_q      <= 1'b0;
                    tlast_q       <= 1'b0;
                end
            endcase
        end
    end

    assign dec_aresetn   = dec_aresetn_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != ST_IDLE);

    mrx_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt  (.clk_i(aclk), .rst_i(areset), .inc_i(ok_inc_s),  .cnt_o(frame_ok_cnt));
    mrx_sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (.clk_i(aclk), .rst_i(areset), .inc_i(bad_inc_s), .cnt_o(frame_bad_cnt));
    mrx_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (.clk_i(aclk), .rst_i(areset), .inc_i(ovf_inc_s), .cnt_o(ovf_cnt));
    mrx_sat_counter #(.CNT_W(CNT_W)) u_to_cnt  (.clk_i(aclk), .rst_i(areset), .inc_i(to_inc_s),  .cnt_o(timeout_cnt));

endmodule

// File: tb/tb_manchester_rx_frame_ctrl.sv
// Directed-plus-random bench for manchester_rx_frame_ctrl with a frame-level reference model.
// Honours MRX_CRC8_EN when building expected checksums.
module tb_manchester_rx_frame_ctrl;

    localparam int FS = 4;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b1;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_in_valid = 1'b0;
    logic          m_axis_tready = 1'b1;
    logic          dec_aresetn, m_axis_tvalid, m_axis_tlast, busy;
    logic [7:0]    m_axis_tdata;
    logic [CW-1:0] frame_ok_cnt, frame_bad_cnt, ovf_cnt, timeout_cnt;

    always #5 aclk = ~aclk;

    manchester_rx_frame_ctrl #(
        .FRAME_SIZE(FS), .TIMEOUT_CYCLES(1024), .RESYNC_CYCLES(4), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .byte_in(byte_in),
        .byte_in_valid(byte_in_valid), .dec_aresetn(dec_aresetn),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_ok_cnt(frame_ok_cnt), .frame_bad_cnt(frame_bad_cnt),
        .ovf_cnt(ovf_cnt), .timeout_cnt(timeout_cnt), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int exp_ok = 0, exp_bad = 0, exp_ovf = 0, exp_to = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] cur[FS];

    // Handshakes are predicted half a cycle ahead; tready only changes just after a rising edge.
    always @(negedge aclk) begin
        if (areset === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
            got_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checksum over cur[0..FS-2]: XOR, or CRC-8 as polynomial long division by x^8+x^2+x+1.
    function automatic logic [7:0] ref_chk();
`ifdef MRX_CRC8_EN
        logic [8*FS-1:0] m;
        m = '0;
        for (int i = 0; i < FS - 1; i++) m[8*FS-1-8*i -: 8] = cur[i];
        for (int i = 8*FS-1; i >= 8; i--) if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return m[7:0];
`else
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < FS - 1; i++) r = r ^ cur[i];
        return r;
`endif
    endfunction

    task automatic make_frame(input bit good);
        for (int i = 0; i < FS - 1; i++) cur[i] = 8'($urandom);
        cur[FS-1] = ref_chk() ^ (good ? 8'h00 : 8'($urandom_range(255, 1)));
    endtask

    task automatic expect_frame();
        for (int i = 0; i < FS - 1; i++) exp_q.push_back({(i == FS - 2), cur[i]});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge aclk);
        byte_in = b;
        byte_in_valid = 1'b1;
        @(negedge aclk);
        byte_in_valid = 1'b0;
        repeat (6) @(negedge aclk);
    endtask

    task automatic send_frame();
        for (int i = 0; i < FS; i++) send_byte(cur[i]);
    endtask

    task automatic set_ready(input logic v);
        @(posedge aclk);
        #2 m_axis_tready = v;
    endtask

    task automatic check_stream(input string tag);
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) @(posedge aclk);
        repeat (10) @(posedge aclk);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_beat"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_ok_cnt"},  frame_ok_cnt,  exp_ok);
        chk({tag, "_bad_cnt"}, frame_bad_cnt, exp_bad);
        chk({tag, "_ovf_cnt"}, ovf_cnt,       exp_ovf);
        chk({tag, "_to_cnt"},  timeout_cnt,   exp_to);
    endtask

    task automatic count_resync(output int n);
        n = 0;
        while (dec_aresetn === 1'b0 && n < 100) begin
            n++;
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] f1_first;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_dec_aresetn", dec_aresetn, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 1);
        check_counters("rst");
        @(negedge aclk);
        areset = 1'b0;
        count_resync(n);
        chk("resync_len", n, 4);
        chk("idle_busy", busy, 0);

        // Directed good frame with latency probe
        cur[0] = 8'h11; cur[1] = 8'h22; cur[2] = 8'h33; cur[3] = ref_chk();
        expect_frame();
        exp_ok++;
        for (int i = 0; i < FS - 1; i++) send_byte(cur[i]);
        @(negedge aclk);
        byte_in = cur[FS-1];
        byte_in_valid = 1'b1;
        @(posedge aclk);
        #1 chk("lat_check_cycle_tvalid", m_axis_tvalid, 0);
        @(negedge aclk);
        byte_in_valid = 1'b0;
        @(posedge aclk);
        #1;
        chk("lat_tvalid", m_axis_tvalid, 1);
        chk("lat_tdata", m_axis_tdata, 8'h11);
        chk("lat_tlast", m_axis_tlast, 0);
        check_stream("good");
        check_counters("good");

        // Directed bad frame
        cur[0] = 8'h11; cur[1] = 8'h22; cur[2] = 8'h33; cur[3] = ref_chk() ^ 8'h01;
        exp_bad++;
        send_frame();
        check_stream("bad");
        check_counters("bad");
        chk("bad_idle", busy, 0);

        // Random good/bad frames
        for (int k = 0; k < 8; k++) begin
            bit good;
            good = 1'($urandom_range(1, 0));
            make_frame(good);
            if (good) begin
                expect_frame();
                exp_ok++;
            end else begin
                exp_bad++;
            end
            send_frame();
        end
        check_stream("rand");
        check_counters("rand");

        // Frame starting while disabled is skipped whole
        enable = 1'b0;
        make_frame(1'b1);
        send_frame();
        enable = 1'b1;
        make_frame(1'b1);
        expect_frame();
        exp_ok++;
        send_frame();
        check_stream("skip");
        check_counters("skip");

        // Backpressure: second frame dropped while output is held
        set_ready(1'b0);
        make_frame(1'b1);
        f1_first = cur[0];
        expect_frame();
        exp_ok++;
        send_frame();
        make_frame(1'b1);
        exp_ovf++;
        send_frame();
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, f1_first);
        set_ready(1'b1);
        repeat (6) @(posedge aclk);
        make_frame(1'b1);
        expect_frame();
        exp_ok++;
        send_frame();
        check_stream("bp");
        check_counters("bp");

        // Timeout mid-frame
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (1000) @(posedge aclk);
        #1;
        chk("pre_timeout_cnt", timeout_cnt, exp_to);
        chk("pre_timeout_dec", dec_aresetn, 1);
        for (int i = 0; i < 100 && dec_aresetn !== 1'b0; i++) begin
            @(posedge aclk);
            #1;
        end
        count_resync(n);
        chk("timeout_resync_len", n, 4);
        exp_to++;
        check_counters("timeout");
        make_frame(1'b1);
        expect_frame();
        exp_ok++;
        send_frame();
        check_stream("post_timeout");

        // Asynchronous reset while a payload is pending
        set_ready(1'b0);
        make_frame(1'b1);
        send_frame();
        chk("pre_rst_tvalid", m_axis_tvalid, 1);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_dec_aresetn", dec_aresetn, 0);
        chk("arst_busy", busy, 1);
        exp_ok = 0; exp_bad = 0; exp_ovf = 0; exp_to = 0;
        check_counters("arst");
        @(negedge aclk);
        areset = 1'b0;
        count_resync(n);
        chk("arst_resync_len", n, 4);
        set_ready(1'b1);
        make_frame(1'b1);
        expect_frame();
        exp_ok++;
        send_frame();
        check_stream("post_rst");
        check_counters("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
